// File: rtl/ref_pkg.sv
// Shared refresh-scheduler constants, used by ref_timer, the DRAM controller and the bench.
// Also holds the saturating debt-step helper.
package ref_pkg;

    localparam int DIV_DEF      = 375;
    localparam int DEBT_MAX_DEF = 7;
    localparam int URG_TH_DEF   = 2;
    localparam int DEBT_W       = 4;
    localparam int PRE_W        = 12;

    function automatic logic [DEBT_W-1:0] debt_step(
        input logic [DEBT_W-1:0] cur,
        input logic              inc,
        input logic              dec,
        input logic [DEBT_W-1:0] max_val
    );
        logic [DEBT_W-1:0] nxt;
        case ({inc, dec})
            2'b10: begin
                if (cur == max_val) begin
                    nxt = cur;
                end else begin
                    nxt = cur + {{(DEBT_W-1){1'b0}}, 1'b1};
                end
            end
            2'b01:   nxt = cur - {{(DEBT_W-1){1'b0}}, 1'b1};
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ref_prescale.sv
// Mod-DIV prescaler: tick is high for the single cycle in which the count sits at DIV-1.
module ref_prescale
    import ref_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic CLK,
    input  logic nRST,
    output logic tick
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] cnt_q;
    logic [PRE_W-1:0] cnt_d;

    // next count: wrap after DIV-1
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {PRE_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(PRE_W-1){1'b0}}, 1'b1};
        end
    end

    // count register, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= {PRE_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/ref_timer.sv
// Refresh scheduler: counts owed refreshes (debt) and drives polite/urgent requests
// to the DRAM controller, dropping both for one cycle after every accepted RefAck.
module ref_timer
    import ref_pkg::*;
#(
    parameter int DIV      = DIV_DEF,
    parameter int DEBT_MAX = DEBT_MAX_DEF,
    parameter int URG_TH   = URG_TH_DEF
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrg,
    output logic              RefOvf,
    output logic [DEBT_W-1:0] Debt
);

    localparam logic [DEBT_W-1:0] DMAX = DEBT_W'(DEBT_MAX);
    localparam logic [DEBT_W-1:0] UTH  = DEBT_W'(URG_TH);

    logic              tick;
    logic              inc;
    logic              dec;
    logic              holdoff;
    logic [DEBT_W-1:0] debt_q, debt_d;
    logic              ovf_q,  ovf_d;
    logic              req_q,  req_d;
    logic              urg_q,  urg_d;

    ref_prescale #(
        .DIV (DIV)
    ) u_prescale (
        .CLK  (CLK),
        .nRST (nRST),
        .tick (tick)
    );

    // debt arithmetic; holdoff blanks the requests for the cycle after an accepted ack
    always_comb begin
        inc     = tick;
        dec     = RefAck && (debt_q != {DEBT_W{1'b0}});
        holdoff = dec;
        debt_d  = debt_step(debt_q, inc, dec, DMAX);
        ovf_d   = ovf_q || (inc && !dec && (debt_q == DMAX));
        req_d   = (debt_d != {DEBT_W{1'b0}}) && !holdoff;
        urg_d   = (debt_d >= UTH) && !holdoff;
    end

    // state and registered outputs; reset wins over every other event
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            debt_q <= {DEBT_W{1'b0}};
            ovf_q  <= 1'b0;
            req_q  <= 1'b0;
            urg_q  <= 1'b0;
        end else begin
            debt_q <= debt_d;
            ovf_q  <= ovf_d;
            req_q  <= req_d;
            urg_q  <= urg_d;
        end
    end

    assign RefReq = req_q;
    assign RefUrg = urg_q;
    assign RefOvf = ovf_q;
    assign Debt   = debt_q;

endmodule

// File: tb/tb_ref_timer.sv
// Directed scoreboard bench for ref_timer at default parameters (DIV=375, DEBT_MAX=7, URG_TH=2).
module tb_ref_timer;
    import ref_pkg::*;

    localparam int D = DIV_DEF;

    logic              clk = 1'b0;
    logic              nrst;
    logic              ack;
    logic              ref_req;
    logic              ref_urg;
    logic              ref_ovf;
    logic [DEBT_W-1:0] debt;

    typedef struct {
        string             tag;
        logic              req;
        logic              urg;
        logic              ovf;
        logic [DEBT_W-1:0] debt;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   ecount = 0;
    bit   live   = 1'b0;

    ref_timer dut (
        .CLK    (clk),
        .nRST   (nrst),
        .RefAck (ack),
        .RefReq (ref_req),
        .RefUrg (ref_urg),
        .RefOvf (ref_ovf),
        .Debt   (debt)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        ecount += n;
    endtask

    task automatic adv_to(input int e);
        if (e > ecount) begin
            adv(e - ecount);
        end
    endtask

    task automatic push(input string tag, input logic r, input logic u, input logic o,
                        input int d);
        exp_t e;
        e.tag  = tag;
        e.req  = r;
        e.urg  = u;
        e.ovf  = o;
        e.debt = DEBT_W'(d);
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL scoreboard_empty: got no entry want one");
        end else begin
            e = sb.pop_front();
            n_chk += 4;
            assert (ref_req === e.req) else begin
                n_err++;
                $error("FAIL %s.RefReq: got %b want %b", e.tag, ref_req, e.req);
            end
            assert (ref_urg === e.urg) else begin
                n_err++;
                $error("FAIL %s.RefUrg: got %b want %b", e.tag, ref_urg, e.urg);
            end
            assert (ref_ovf === e.ovf) else begin
                n_err++;
                $error("FAIL %s.RefOvf: got %b want %b", e.tag, ref_ovf, e.ovf);
            end
            assert (debt === e.debt) else begin
                n_err++;
                $error("FAIL %s.Debt: got %0d want %0d", e.tag, debt, e.debt);
            end
        end
    endtask

    // an urgent request without the polite one is never legal
    always @(negedge clk) begin
        if (live) begin
            n_chk++;
            assert ((ref_urg && !ref_req) !== 1'b1) else begin
                n_err++;
                $error("FAIL urg_implies_req: got RefUrg=%b RefReq=%b want RefReq=1",
                       ref_urg, ref_req);
            end
        end
    end

    initial begin
        nrst = 1'b0;
        ack  = 1'b0;
        adv(3);
        push("reset", 1'b0, 1'b0, 1'b0, 0);
        check_out();
        live   = 1'b1;

        // release; edge count is measured from the last reset edge
        nrst   = 1'b1;
        ecount = 0;
        adv_to(D - 1);
        push("pre_tick1", 1'b0, 1'b0, 1'b0, 0);
        check_out();
        adv_to(D);
        push("tick1", 1'b1, 1'b0, 1'b0, 1);
        check_out();
        adv_to(2 * D);
        push("tick2", 1'b1, 1'b1, 1'b0, 2);
        check_out();

        ack = 1'b1;
        push("ack_d2_hold", 1'b0, 1'b0, 1'b0, 1);
        adv(1);
        ack = 1'b0;
        check_out();
        push("ack_d2_after", 1'b1, 1'b0, 1'b0, 1);
        adv(1);
        check_out();

        ack = 1'b1;
        push("ack_d1", 1'b0, 1'b0, 1'b0, 0);
        adv(1);
        ack = 1'b0;
        check_out();

        adv_to(2 * D + 10);
        ack = 1'b1;
        push("ack_d0", 1'b0, 1'b0, 1'b0, 0);
        adv(1);
        ack = 1'b0;
        check_out();
        adv_to(3 * D - 1);
        push("quiet_to_tick", 1'b0, 1'b0, 1'b0, 0);
        check_out();
        adv_to(3 * D);
        push("tick3", 1'b1, 1'b0, 1'b0, 1);
        check_out();

        adv_to(5 * D);
        push("debt3", 1'b1, 1'b1, 1'b0, 3);
        check_out();
        ack = 1'b1;
        push("ack_d3_hold", 1'b0, 1'b0, 1'b0, 2);
        adv(1);
        ack = 1'b0;
        check_out();
        push("ack_d3_after", 1'b1, 1'b1, 1'b0, 2);
        adv(1);
        check_out();

        // ack lands in the tick cycle: debt unchanged, holdoff still pulses
        adv_to(6 * D - 1);
        ack = 1'b1;
        push("tick_ack_hold", 1'b0, 1'b0, 1'b0, 2);
        adv(1);
        ack = 1'b0;
        check_out();
        push("tick_ack_after", 1'b1, 1'b1, 1'b0, 2);
        adv(1);
        check_out();

        for (int k = 3; k <= 7; k++) begin
            adv_to((k + 4) * D);
            push("climb", 1'b1, 1'b1, 1'b0, k);
            check_out();
        end
        adv_to(12 * D - 1);
        push("sat_pre_ovf", 1'b1, 1'b1, 1'b0, 7);
        check_out();
        adv_to(12 * D);
        push("sat_ovf", 1'b1, 1'b1, 1'b1, 7);
        check_out();

        for (int d = 7; d >= 1; d--) begin
            ack = 1'b1;
            push("drain_hold", 1'b0, 1'b0, 1'b1, d - 1);
            adv(1);
            ack = 1'b0;
            check_out();
            push("drain_after", (d - 1) != 0, (d - 1) >= URG_TH_DEF, 1'b1, d - 1);
            adv(1);
            check_out();
        end

        adv_to(16 * D + 100);
        push("debt4_mid", 1'b1, 1'b1, 1'b1, 4);
        check_out();
        nrst = 1'b0;
        ack  = 1'b1;
        push("rst_with_ack", 1'b0, 1'b0, 1'b0, 0);
        adv(1);
        check_out();
        nrst   = 1'b1;
        ack    = 1'b0;
        ecount = 0;
        adv_to(D - 1);
        push("restart_pre", 1'b0, 1'b0, 1'b0, 0);
        check_out();
        adv_to(D);
        push("restart_tick", 1'b1, 1'b0, 1'b0, 1);
        check_out();

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $error("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
